// File: rtl/w0rm_peripheral_memory_dp_pkg.sv
// Shared helpers for the W0RM dual-port memory: log2, address-span end and
// derived widths used by the decode logic.
package w0rm_mem_pkg;

  localparam int unsigned BYTE_BITS = 8;

  function automatic int unsigned log2c(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Byte offset bits inside one word.
  function automatic int unsigned off_bits(input int unsigned data_width);
    return log2c(data_width / BYTE_BITS);
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? log2c(depth) : 1;
  endfunction

  // One past the last byte address; one extra bit so the top cannot wrap.
  function automatic logic [64:0] span_end(input logic [63:0] base,
                                           input int unsigned depth,
                                           input int unsigned bytes);
    return {1'b0, base} + (65'(depth) * 65'(bytes));
  endfunction

endpackage

// File: rtl/w0rm_peripheral_memory_dp_if.sv
// One W0RM memory bus port: request strobes/payload in, response out.
interface w0rm_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32
);
  logic                    valid_i;
  logic                    read_i;
  logic                    write_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [USER_WIDTH-1:0]   user_i;
  logic                    valid_o;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    err_o;
  logic [USER_WIDTH-1:0]   user_o;

  modport master (
    output valid_i, read_i, write_i, addr_i, data_i, be_i, user_i,
    input  valid_o, data_o, err_o, user_o
  );

  modport slave (
    input  valid_i, read_i, write_i, addr_i, data_i, be_i, user_i,
    output valid_o, data_o, err_o, user_o
  );
endinterface

// File: rtl/w0rm_peripheral_memory_dp_resp_pipe.sv
// Response register chain for one port: one stage for latency 1, two for
// latency 2. Payload only advances with valid so idle outputs hold.
module w0rm_mem_resp_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int USER_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_err,
  input  logic [USER_WIDTH-1:0] req_user,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [USER_WIDTH-1:0] rsp_user
);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_err;
  logic [USER_WIDTH-1:0] s1_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
      s1_user  <= '0;
    end else begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_data <= req_data;
        s1_err  <= req_err;
        s1_user <= req_user;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_two
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_err;
      logic [USER_WIDTH-1:0] s2_user;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_err   <= 1'b0;
          s2_user  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
            s2_err  <= s1_err;
            s2_user <= s1_user;
          end
        end
      end

      assign rsp_valid = s2_valid;
      assign rsp_data  = s2_data;
      assign rsp_err   = s2_err;
      assign rsp_user  = s2_user;
    end else begin : g_one
      assign rsp_valid = s1_valid;
      assign rsp_data  = s1_data;
      assign rsp_err   = s1_err;
      assign rsp_user  = s1_user;
    end
  endgenerate

endmodule

// File: rtl/w0rm_peripheral_memory_dp.sv
// Dual-port byte-addressed RAM on the W0RM bus with byte enables, range
// decode with error response, read-first ports and 1/2-cycle latency.
module w0rm_peripheral_memory_dp
  import w0rm_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_DEPTH    = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
  parameter string                 INIT_FILE    = "",
  parameter int                    USER_WIDTH   = 32,
  parameter int                    READ_LATENCY = 1
) (
  input logic       mem_clk,
  input logic       mem_reset,
  w0rm_mem_if.slave mem_a,
  w0rm_mem_if.slave mem_b
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = int'(off_bits(DATA_WIDTH));
  localparam int IDX_W = int'(idx_width(MEM_DEPTH));
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] END_EXT  =
    (ADDR_WIDTH+1)'(span_end(64'(BASE_ADDR), MEM_DEPTH, BYTES));

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a positive multiple of 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // The array starts cleared.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < END_EXT);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] rel;
    rel = addr - BASE_ADDR;
    return IDX_W'(rel >> OFF);
  endfunction

  logic             a_acc, a_hit, a_we;
  logic             b_acc, b_hit, b_we;
  logic [IDX_W-1:0] a_idx, b_idx;

  always_comb begin
    a_acc = mem_a.valid_i && (mem_a.read_i || mem_a.write_i);
    a_hit = in_range(mem_a.addr_i);
    a_idx = word_index(mem_a.addr_i);
    a_we  = a_acc && a_hit && mem_a.write_i && !mem_reset;
    b_acc = mem_b.valid_i && (mem_b.read_i || mem_b.write_i);
    b_hit = in_range(mem_b.addr_i);
    b_idx = word_index(mem_b.addr_i);
    b_we  = b_acc && b_hit && mem_b.write_i && !mem_reset;
  end

  // B's bytes are scheduled first so A's enabled bytes override on a shared word.
  always_ff @(posedge mem_clk) begin
    for (int k = 0; k < BYTES; k++) begin
      if (b_we && mem_b.be_i[k]) mem[b_idx][k*8 +: 8] <= mem_b.data_i[k*8 +: 8];
    end
    for (int k = 0; k < BYTES; k++) begin
      if (a_we && mem_a.be_i[k]) mem[a_idx][k*8 +: 8] <= mem_a.data_i[k*8 +: 8];
    end
  end

  w0rm_mem_resp_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH), .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk      (mem_clk),
    .rst      (mem_reset),
    .req_valid(a_acc),
    .req_data (a_hit ? mem[a_idx] : '0),
    .req_err  (!a_hit),
    .req_user (mem_a.user_i),
    .rsp_valid(mem_a.valid_o),
    .rsp_data (mem_a.data_o),
    .rsp_err  (mem_a.err_o),
    .rsp_user (mem_a.user_o)
  );

  w0rm_mem_resp_pipe #(
    .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH), .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk      (mem_clk),
    .rst      (mem_reset),
    .req_valid(b_acc),
    .req_data (b_hit ? mem[b_idx] : '0),
    .req_err  (!b_hit),
    .req_user (mem_b.user_i),
    .rsp_valid(mem_b.valid_o),
    .rsp_data (mem_b.data_o),
    .rsp_err  (mem_b.err_o),
    .rsp_user (mem_b.user_o)
  );

endmodule

// File: tb/tb_w0rm_peripheral_memory_dp.sv
// Bench for the dual-port memory: latency-1 and latency-2 instances share the
// same stimulus and are compared each cycle against a word-array model.
module tb_w0rm_peripheral_memory_dp;

  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] user;
  } req_t;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        err;
    logic [31:0] user;
    bit          ek;
  } rsp_t;

  req_t ra, rb;
  rsp_t e1 [2];
  rsp_t e2 [2];
  logic [31:0] mem_m [DEPTH];
  int total = 0;
  int fails = 0;

  w0rm_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(32)) a1 (), b1 (), a2 (), b2 ();

  w0rm_peripheral_memory_dp #(.READ_LATENCY(1)) u_lat1 (
    .mem_clk(clk), .mem_reset(rst), .mem_a(a1), .mem_b(b1)
  );
  w0rm_peripheral_memory_dp #(.READ_LATENCY(2)) u_lat2 (
    .mem_clk(clk), .mem_reset(rst), .mem_a(a2), .mem_b(b2)
  );

  function automatic req_t idle();
    req_t q;
    q = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
    return q;
  endfunction

  function automatic req_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] be, logic [31:0] user);
    req_t q;
    q = '{1'b1, rd, wr, addr, data, be, user};
    return q;
  endfunction

  function automatic bit inRange(logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + DEPTH * 4);
  endfunction

  function automatic int wordIdx(logic [31:0] a);
    return int'(((a - BASE) / 4) % DEPTH);
  endfunction

  // Drive both DUT copies with the same requests.
  task automatic applyStimulus(input req_t x, input req_t y, input logic r);
    ra = x; rb = y; rst = r;
    a1.valid_i = x.valid; a2.valid_i = x.valid; b1.valid_i = y.valid; b2.valid_i = y.valid;
    a1.read_i  = x.rd;    a2.read_i  = x.rd;    b1.read_i  = y.rd;    b2.read_i  = y.rd;
    a1.write_i = x.wr;    a2.write_i = x.wr;    b1.write_i = y.wr;    b2.write_i = y.wr;
    a1.addr_i  = x.addr;  a2.addr_i  = x.addr;  b1.addr_i  = y.addr;  b2.addr_i  = y.addr;
    a1.data_i  = x.data;  a2.data_i  = x.data;  b1.data_i  = y.data;  b2.data_i  = y.data;
    a1.be_i    = x.be;    a2.be_i    = x.be;    b1.be_i    = y.be;    b2.be_i    = y.be;
    a1.user_i  = x.user;  a2.user_i  = x.user;  b1.user_i  = y.user;  b2.user_i  = y.user;
  endtask

  task automatic applyWrite(input req_t q);
    int idx;
    if (q.valid && q.wr && inRange(q.addr)) begin
      idx = wordIdx(q.addr);
      for (int k = 0; k < 4; k++) if (q.be[k]) mem_m[idx][k*8 +: 8] = q.data[k*8 +: 8];
    end
  endtask

  // Expected outputs after one edge; latency 2 sees the latency-1 result a cycle later.
  task automatic modelEdge();
    rsp_t n1 [2];
    req_t q;
    for (int p = 0; p < 2; p++) begin
      q = (p == 0) ? ra : rb;
      if (rst) n1[p] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
      else if (q.valid && (q.rd || q.wr))
        n1[p] = '{1'b1, inRange(q.addr) ? mem_m[wordIdx(q.addr)] : 32'h0,
                  !inRange(q.addr), q.user, 1'b1};
      else begin
        n1[p] = e1[p];
        n1[p].valid = 1'b0;
        n1[p].ek = 1'b0;
      end
      if (rst) e2[p] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
      else if (e1[p].valid) e2[p] = e1[p];
      else begin
        e2[p].valid = 1'b0;
        e2[p].ek = 1'b0;
      end
    end
    e1 = n1;
    if (!rst) begin
      applyWrite(rb);
      applyWrite(ra);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkPort(input string tag, input rsp_t x, input logic v,
                           input logic [31:0] d, input logic e, input logic [31:0] u);
    checkVal({tag, ".valid"}, {31'h0, v}, {31'h0, x.valid});
    checkVal({tag, ".data"}, d, x.data);
    checkVal({tag, ".user"}, u, x.user);
    if (x.ek) checkVal({tag, ".err"}, {31'h0, e}, {31'h0, x.err});
  endtask

  task automatic checkOutput(input string tag);
    checkPort({tag, "/lat1_a"}, e1[0], a1.valid_o, a1.data_o, a1.err_o, a1.user_o);
    checkPort({tag, "/lat1_b"}, e1[1], b1.valid_o, b1.data_o, b1.err_o, b1.user_o);
    checkPort({tag, "/lat2_a"}, e2[0], a2.valid_o, a2.data_o, a2.err_o, a2.user_o);
    checkPort({tag, "/lat2_b"}, e2[1], b2.valid_o, b2.data_o, b2.err_o, b2.user_o);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] addr;
    int          mode;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      e1[p] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
      e2[p] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    end

    applyStimulus(idle(), idle(), 1'b1);
    step("reset0");
    step("reset1");

    for (int i = 0; i < DEPTH / 2; i++) begin
      applyStimulus(mk(0, 1, BASE + 8 * i, $urandom, 4'hF, i),
                    mk(0, 1, BASE + 8 * i + 4, $urandom, 4'hF, i + 1000), 1'b0);
      step("fill");
    end

    applyStimulus(mk(0, 1, BASE + 'h10, 32'hDEADBEEF, 4'hF, 32'h11), idle(), 1'b0);
    step("rt_wr");
    applyStimulus(mk(1, 0, BASE + 'h10, 32'h0, 4'h0, 32'h22), idle(), 1'b0);
    step("rt_rd");
    checkVal("rt_lat1_data", a1.data_o, 32'hDEADBEEF);
    checkVal("rt_lat1_user", a1.user_o, 32'h22);
    checkVal("rt_lat2_user_first", a2.user_o, 32'h11);
    applyStimulus(idle(), idle(), 1'b0);
    step("rt_idle");
    checkVal("rt_lat2_valid", {31'h0, a2.valid_o}, 32'h1);
    checkVal("rt_lat2_data", a2.data_o, 32'hDEADBEEF);
    checkVal("rt_lat1_idle_valid", {31'h0, a1.valid_o}, 32'h0);

    applyStimulus(mk(0, 1, BASE + 'h20, 32'h11223344, 4'hF, 32'h1), idle(), 1'b0);
    step("be_init");
    applyStimulus(mk(0, 1, BASE + 'h20, 32'hAABBCCDD, 4'b0101, 32'h2), idle(), 1'b0);
    step("be_wr");
    applyStimulus(mk(1, 0, BASE + 'h20, 32'h0, 4'h0, 32'h3), idle(), 1'b0);
    step("be_rd");
    checkVal("be_data", a1.data_o, 32'h11BB33DD);

    applyStimulus(mk(1, 0, BASE + 'h7FC, 32'h0, 4'h0, 32'h4), idle(), 1'b0);
    step("edge_top");
    checkVal("edge_top_err", {31'h0, a1.err_o}, 32'h0);
    applyStimulus(mk(1, 0, BASE + 'h800, 32'h0, 4'h0, 32'h5), idle(), 1'b0);
    step("edge_past");
    checkVal("edge_past_err", {31'h0, a1.err_o}, 32'h1);
    checkVal("edge_past_data", a1.data_o, 32'h0);
    applyStimulus(idle(), mk(1, 0, 32'h3FFF_FFFC, 32'h0, 4'h0, 32'h6), 1'b0);
    step("edge_below");
    checkVal("edge_below_err", {31'h0, b1.err_o}, 32'h1);
    applyStimulus(mk(0, 1, BASE + 'h800, 32'hCAFEF00D, 4'hF, 32'h7), idle(), 1'b0);
    step("edge_oor_wr");
    applyStimulus(mk(1, 0, BASE, 32'h0, 4'h0, 32'h8),
                  mk(1, 0, BASE + 'h7FC, 32'h0, 4'h0, 32'h9), 1'b0);
    step("edge_readback");

    applyStimulus(mk(0, 1, BASE + 'h40, 32'h0000_0001, 4'h3, 32'hA),
                  mk(0, 1, BASE + 'h40, 32'hFFFF_FFFF, 4'hF, 32'hB), 1'b0);
    step("col_ww");
    applyStimulus(mk(1, 0, BASE + 'h40, 32'h0, 4'h0, 32'hC), idle(), 1'b0);
    step("col_ww_rd");
    checkVal("col_ww_data", a1.data_o, 32'hFFFF_0001);
    applyStimulus(mk(0, 1, BASE + 'h40, 32'h5555_AAAA, 4'hF, 32'hD),
                  mk(1, 0, BASE + 'h40, 32'h0, 4'h0, 32'hE), 1'b0);
    step("col_wr");
    checkVal("col_wr_old", b1.data_o, 32'hFFFF_0001);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(1, 0, BASE + 4 * i, 32'h0, 4'h0, i), idle(), 1'b0);
      step("stream");
      checkVal("stream_user", a1.user_o, i);
    end
    applyStimulus(idle(), idle(), 1'b0);
    step("stream_end");

    applyStimulus(mk(1, 0, BASE + 'h10, 32'h0, 4'h0, 32'h77), idle(), 1'b0);
    step("rst_rd");
    applyStimulus(mk(0, 1, BASE + 'h10, 32'h1234_5678, 4'hF, 32'h78), idle(), 1'b1);
    step("rst_on");
    checkVal("rst_lat2_valid", {31'h0, a2.valid_o}, 32'h0);
    checkVal("rst_lat1_data", a1.data_o, 32'h0);
    applyStimulus(idle(), idle(), 1'b0);
    step("rst_off");
    checkVal("rst_drop_lat2", {31'h0, a2.valid_o}, 32'h0);
    applyStimulus(mk(1, 0, BASE + 'h10, 32'h0, 4'h0, 32'h79), idle(), 1'b0);
    step("rst_after_rd");
    checkVal("rst_kept_data", a1.data_o, 32'hDEADBEEF);

    for (int c = 0; c < 400; c++) begin
      req_t q [2];
      for (int p = 0; p < 2; p++) begin
        mode = int'($urandom_range(0, 9));
        if (mode < 7) addr = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
        else if (mode < 9) addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
        else addr = ($urandom_range(0, 1) == 1) ? BASE + 'h800 + 4 * $urandom_range(0, 63)
                                               : BASE - 4 * $urandom_range(1, 64);
        q[p] = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, addr,
                  $urandom, 4'($urandom), $urandom);
        q[p].valid = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(q[0], q[1], $urandom_range(0, 49) == 0);
      step("rand");
    end

    applyStimulus(idle(), idle(), 1'b0);
    step("drain0");
    step("drain1");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
